hazard_ctrl: RTL

- Central hazard controller for the 5-stage pipeline.
- Drives the en (stall) and clear (flush) inputs of the stage flopenr/flopr registers.
- Computes forwarding selects.
- Runs a small FSM that freezes the pipeline while a multicycle multiply/divide (MDU) op in Execute completes.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load/branch stalls, MDU freeze FSM, stall counter.
// Forwarding and stall/flush are combinational; mdudoneE and stallcnt are registered.
module hazard_ctrl #(
  parameter int REGBITS    = 5,
  parameter int MDU_CYCLES = 32,
  parameter int CNTW       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGBITS-1:0] rsD,
  input  logic [REGBITS-1:0] rtD,
  input  logic [REGBITS-1:0] rsE,
  input  logic [REGBITS-1:0] rtE,
  input  logic [REGBITS-1:0] writeregE,
  input  logic [REGBITS-1:0] writeregM,
  input  logic [REGBITS-1:0] writeregW,
  input  logic               regwriteE,
  input  logic               regwriteM,
  input  logic               regwriteW,
  input  logic               memtoregE,
  input  logic               memtoregM,
  input  logic               branchD,
  input  logic               pcsrcD,
  input  logic               mdustartE,
  output logic [1:0]         forwardAE,
  output logic [1:0]         forwardBE,
  output logic               forwardAD,
  output logic               forwardBD,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic               mdudoneE,
  output logic [CNTW-1:0]    stallcnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(MDU_CYCLES - 2);

  state_t     state;
  logic [7:0] cnt;
  logic       lwstall;
  logic       branchstall;
  logic       mdustall;

  always_comb begin
    forwardAE = 2'b00;
    if (rsE != '0 && regwriteM && rsE == writeregM)      forwardAE = 2'b10;
    else if (rsE != '0 && regwriteW && rsE == writeregW) forwardAE = 2'b01;
    forwardBE = 2'b00;
    if (rtE != '0 && regwriteM && rtE == writeregM)      forwardBE = 2'b10;
    else if (rtE != '0 && regwriteW && rtE == writeregW) forwardBE = 2'b01;
  end

  assign forwardAD = (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardBD = (rtD != '0) && regwriteM && (rtD == writeregM);

  assign lwstall     = memtoregE && (rtE == rsD || rtE == rtD);
  assign branchstall = branchD &&
                       ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                        (memtoregM && (writeregM == rsD || writeregM == rtD)));

  // The IDLE-cycle stall is combinational so the op is frozen the cycle it arrives;
  // gating with reset lets the freeze drop the instant reset asserts.
  assign mdustall = reset && ((state == IDLE && mdustartE) || state == BUSY);
  assign mdudoneE = (state == DONE);

  assign stallF = lwstall || branchstall || mdustall;
  assign stallD = stallF;
  assign stallE = mdustall;
  assign flushM = mdustall;
  assign flushE = (lwstall || branchstall) && !mdustall;
  assign flushD = pcsrcD && !stallD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      stallcnt <= '0;
    end else begin
      case (state)
        IDLE: if (mdustartE) begin
          state <= BUSY;
          cnt   <= CNT_INIT;
        end
        BUSY: if (cnt == 8'd0) state <= DONE;
              else             cnt   <= cnt - 8'd1;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (stallF && stallcnt != '1) stallcnt <= stallcnt + CNTW'(1);
    end
  end

endmodule
